// File: rtl/mips_lite_pkg.sv
// Shared MIPS-lite definitions: opcodes, instruction field positions,
// and the decoded control bundle passed from the decoder to ID.
package mips_lite_pkg;

  localparam int XLEN      = 32;
  localparam int NREG_BITS = 5;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  typedef enum logic [5:0] {
    OP_ADD  = 6'h00,
    OP_ADDI = 6'h01,
    OP_SUB  = 6'h02,
    OP_SUBI = 6'h03,
    OP_MUL  = 6'h04,
    OP_MULI = 6'h05,
    OP_OR   = 6'h06,
    OP_ORI  = 6'h07,
    OP_AND  = 6'h08,
    OP_ANDI = 6'h09,
    OP_XOR  = 6'h0A,
    OP_XORI = 6'h0B,
    OP_LDW  = 6'h0C,
    OP_STW  = 6'h0D,
    OP_BZ   = 6'h0E,
    OP_BEQ  = 6'h0F,
    OP_JR   = 6'h10,
    OP_HALT = 6'h11
  } op_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic use_imm;
    logic branch;
    logic halt;
    logic illegal;
    logic dest_rt;
    logic use_rs;
    logic use_rt;
  } ctrl_t;

endpackage

// File: rtl/id_stage_if.sv
// ID/EX bundle: registered decode results presented to EX.
// master = ID stage (drives), slave = EX stage (consumes).
interface id_stage_if #(
  parameter int XLEN = 32
);
  logic            ex_valid;
  logic [5:0]      ex_opcode;
  logic [XLEN-1:0] ex_a;
  logic [XLEN-1:0] ex_b;
  logic [XLEN-1:0] ex_imm;
  logic [4:0]      ex_rd;
  logic [XLEN-1:0] ex_pc;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic            ex_use_imm;
  logic            ex_branch;
  logic            ex_halt;
  logic            ex_illegal;

  modport master (
    output ex_valid, ex_opcode, ex_a, ex_b,
    output ex_imm, ex_rd, ex_pc,
    output ex_reg_write, ex_mem_read,
    output ex_mem_write, ex_use_imm,
    output ex_branch, ex_halt, ex_illegal
  );

  modport slave (
    input ex_valid, ex_opcode, ex_a, ex_b,
    input ex_imm, ex_rd, ex_pc,
    input ex_reg_write, ex_mem_read,
    input ex_mem_write, ex_use_imm,
    input ex_branch, ex_halt, ex_illegal
  );
endinterface

// File: rtl/id_decoder.sv
// Combinational opcode decoder: opcode -> control bits, dest select,
// source-use flags and illegal flag.
module id_decoder
  import mips_lite_pkg::*;
(
  input  logic [5:0] op,
  output ctrl_t      ctrl
);

  logic alu_grp;
  assign alu_grp = (op <= OP_XORI);

  always_comb begin
    ctrl = '0;
    unique case (1'b1)
      alu_grp && !op[0]: begin
        ctrl.reg_write = 1'b1;
        ctrl.use_rs    = 1'b1;
        ctrl.use_rt    = 1'b1;
      end
      alu_grp && op[0]: begin
        ctrl.reg_write = 1'b1;
        ctrl.use_imm   = 1'b1;
        ctrl.dest_rt   = 1'b1;
        ctrl.use_rs    = 1'b1;
      end
      op == OP_LDW: begin
        ctrl.reg_write = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.dest_rt   = 1'b1;
        ctrl.use_rs    = 1'b1;
      end
      op == OP_STW: begin
        ctrl.mem_write = 1'b1;
        ctrl.use_rs    = 1'b1;
        ctrl.use_rt    = 1'b1;
      end
      op == OP_BZ: begin
        ctrl.branch = 1'b1;
        ctrl.use_rs = 1'b1;
      end
      op == OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.use_rs = 1'b1;
        ctrl.use_rt = 1'b1;
      end
      op == OP_JR: begin
        ctrl.branch = 1'b1;
        ctrl.use_rs = 1'b1;
      end
      op == OP_HALT: begin
        ctrl.halt = 1'b1;
      end
      default: begin
        ctrl.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// ID stage: decode, regfile read with WB bypass, load-use stall,
// flush/halt handling and the ID/EX register (ports: IF in, rf, WB, ex).
module id_stage
  import mips_lite_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NREG_BITS = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 if_valid,
  input  logic [31:0]          if_instr,
  input  logic [XLEN-1:0]      if_pc,
  output logic                 id_stall,
  output logic [NREG_BITS-1:0] rf_rs1,
  output logic [NREG_BITS-1:0] rf_rs2,
  input  logic [XLEN-1:0]      rf_rd1,
  input  logic [XLEN-1:0]      rf_rd2,
  input  logic                 wb_we,
  input  logic [NREG_BITS-1:0] wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 flush,
  id_stage_if.master           ex
);

  logic [5:0]           op;
  logic [NREG_BITS-1:0] rs, rt, rd, dest;
  logic [15:0]          imm;
  ctrl_t                ctrl;
  logic [XLEN-1:0]      a, b;
  logic                 halted;
  logic                 hazard;
  logic                 issue;

  assign op  = if_instr[OPC_HI:OPC_LO];
  assign rs  = if_instr[RS_HI:RS_LO];
  assign rt  = if_instr[RT_HI:RT_LO];
  assign rd  = if_instr[RD_HI:RD_LO];
  assign imm = if_instr[IMM_HI:IMM_LO];

  assign rf_rs1 = rs;
  assign rf_rs2 = rt;

  id_decoder u_dec (
    .op   (op),
    .ctrl (ctrl)
  );

  assign dest = ctrl.dest_rt ? rt : rd;

  // r0 is hard-wired zero; a same-cycle WB write wins over the regfile.
  always_comb begin
    a = rf_rd1;
    b = rf_rd2;
    if (wb_we && wb_rd != '0 && wb_rd == rs)
      a = wb_data;
    if (wb_we && wb_rd != '0 && wb_rd == rt)
      b = wb_data;
    if (rs == '0)
      a = '0;
    if (rt == '0)
      b = '0;
  end

  // Load in EX whose result a source of this instruction needs.
  assign hazard = if_valid && ex.ex_valid &&
                  ex.ex_mem_read && ex.ex_rd != '0 &&
                  ((ctrl.use_rs && ex.ex_rd == rs) ||
                   (ctrl.use_rt && ex.ex_rd == rt));

  assign id_stall = !flush && (halted || hazard);
  assign issue    = if_valid && !flush &&
                    !halted && !hazard;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      halted          <= 1'b0;
      ex.ex_valid     <= 1'b0;
      ex.ex_opcode    <= '0;
      ex.ex_a         <= '0;
      ex.ex_b         <= '0;
      ex.ex_imm       <= '0;
      ex.ex_rd        <= '0;
      ex.ex_pc        <= '0;
      ex.ex_reg_write <= 1'b0;
      ex.ex_mem_read  <= 1'b0;
      ex.ex_mem_write <= 1'b0;
      ex.ex_use_imm   <= 1'b0;
      ex.ex_branch    <= 1'b0;
      ex.ex_halt      <= 1'b0;
      ex.ex_illegal   <= 1'b0;
    end else begin
      if (issue && ctrl.halt)
        halted <= 1'b1;
      ex.ex_valid     <= issue;
      ex.ex_opcode    <= op;
      ex.ex_a         <= a;
      ex.ex_b         <= b;
      ex.ex_imm       <= {{(XLEN-16){imm[15]}}, imm};
      ex.ex_rd        <= dest;
      ex.ex_pc        <= if_pc;
      ex.ex_reg_write <= issue && ctrl.reg_write &&
                         dest != '0;
      ex.ex_mem_read  <= issue && ctrl.mem_read;
      ex.ex_mem_write <= issue && ctrl.mem_write;
      ex.ex_use_imm   <= issue && ctrl.use_imm;
      ex.ex_branch    <= issue && ctrl.branch;
      ex.ex_halt      <= issue && ctrl.halt;
      ex.ex_illegal   <= issue && ctrl.illegal;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage.
// Regfile is modelled by a small array indexed by rf_rs1/rf_rs2.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_stall;
  logic [4:0]  rf_rs1, rf_rs2;
  logic [31:0] rf_rd1, rf_rd2;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic [31:0] regs [32];

  int checks = 0;
  int failures = 0;

  id_stage_if ex_if ();

  id_stage dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .if_valid (if_valid),
    .if_instr (if_instr),
    .if_pc    (if_pc),
    .id_stall (id_stall),
    .rf_rs1   (rf_rs1),
    .rf_rs2   (rf_rs2),
    .rf_rd1   (rf_rd1),
    .rf_rd2   (rf_rd2),
    .wb_we    (wb_we),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .flush    (flush),
    .ex       (ex_if)
  );

  always #5 clk = ~clk;

  assign rf_rd1 = regs[rf_rs1];
  assign rf_rd2 = regs[rf_rs2];

  localparam logic [31:0] I_ADD    = 32'h0022_1800;
  localparam logic [31:0] I_LDW    = 32'h3024_0000;
  localparam logic [31:0] I_ADD2   = 32'h0081_2800;
  localparam logic [31:0] I_ADDIM1 = 32'h0422_FFFF;
  localparam logic [31:0] I_ADDIR0 = 32'h0420_0003;
  localparam logic [31:0] I_ORI    = 32'h1C24_0001;
  localparam logic [31:0] I_ADDR0  = 32'h0002_3000;
  localparam logic [31:0] I_BEQ    = 32'h3C22_0004;
  localparam logic [31:0] I_HALT   = 32'h4400_0000;
  localparam logic [31:0] I_ILL    = 32'hFC00_0000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins,
                       input logic [31:0] pc);
    if_valid = v;
    if_instr = ins;
    if_pc    = pc;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1'b1, I_ADD, 32'h0);
    #3;
    checks++;
    if (ex_if.ex_valid !== 1'b0 || id_stall !== 1'b0) begin
      failures++;
      $display("FAIL reset got valid=%b stall=%b exp 0 0",
               ex_if.ex_valid, id_stall);
    end
    checks++;
    if ({ex_if.ex_reg_write, ex_if.ex_mem_read, ex_if.ex_halt,
         ex_if.ex_illegal, ex_if.ex_a} !== 36'h0) begin
      failures++;
      $display("FAIL reset_ctrl got nonzero ex fields, exp 0");
    end
    drive(1'b0, 32'h0, 32'h0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    drive(1'b1, I_ADD, 32'h100);
    #1;
    checks++;
    if (rf_rs1 !== 5'd1 || rf_rs2 !== 5'd2) begin
      failures++;
      $display("FAIL rf_addr got %0d %0d exp 1 2", rf_rs1, rf_rs2);
    end
    checks++;
    if (id_stall !== 1'b0) begin
      failures++;
      $display("FAIL add_stall got %b exp 0", id_stall);
    end
    tick();
    checks++;
    if (ex_if.ex_valid !== 1'b1 || ex_if.ex_a !== 32'd5 ||
        ex_if.ex_b !== 32'd7 || ex_if.ex_rd !== 5'd3 ||
        ex_if.ex_reg_write !== 1'b1 || ex_if.ex_pc !== 32'h100) begin
      failures++;
      $display("FAIL add got v=%b a=%h b=%h rd=%0d rw=%b pc=%h exp 1 5 7 3 1 100",
               ex_if.ex_valid, ex_if.ex_a, ex_if.ex_b, ex_if.ex_rd,
               ex_if.ex_reg_write, ex_if.ex_pc);
    end
    drive(1'b1, I_ADDR0, 32'h104);
    tick();
    checks++;
    if (ex_if.ex_a !== 32'd0 || ex_if.ex_b !== 32'd7 ||
        ex_if.ex_rd !== 5'd6) begin
      failures++;
      $display("FAIL r0_read got a=%h b=%h rd=%0d exp 0 7 6",
               ex_if.ex_a, ex_if.ex_b, ex_if.ex_rd);
    end
    drive(1'b1, I_BEQ, 32'h108);
    tick();
    checks++;
    if (ex_if.ex_branch !== 1'b1 || ex_if.ex_reg_write !== 1'b0 ||
        ex_if.ex_imm !== 32'd4 || ex_if.ex_opcode !== 6'h0F) begin
      failures++;
      $display("FAIL beq got br=%b rw=%b imm=%h op=%h exp 1 0 4 0f",
               ex_if.ex_branch, ex_if.ex_reg_write, ex_if.ex_imm,
               ex_if.ex_opcode);
    end
    drive(1'b0, 32'h0, 32'h0);
    tick();
    checks++;
    if (ex_if.ex_valid !== 1'b0 || ex_if.ex_branch !== 1'b0) begin
      failures++;
      $display("FAIL idle_bubble got v=%b br=%b exp 0 0",
               ex_if.ex_valid, ex_if.ex_branch);
    end
  endtask

  task automatic test_load_use();
    drive(1'b1, I_LDW, 32'h200);
    tick();
    checks++;
    if (ex_if.ex_mem_read !== 1'b1 || ex_if.ex_rd !== 5'd4) begin
      failures++;
      $display("FAIL ldw got mr=%b rd=%0d exp 1 4",
               ex_if.ex_mem_read, ex_if.ex_rd);
    end
    drive(1'b1, I_ADD2, 32'h204);
    #1;
    checks++;
    if (id_stall !== 1'b1) begin
      failures++;
      $display("FAIL lu_stall got %b exp 1", id_stall);
    end
    tick();
    checks++;
    if (ex_if.ex_valid !== 1'b0 || ex_if.ex_reg_write !== 1'b0 ||
        id_stall !== 1'b0) begin
      failures++;
      $display("FAIL lu_bubble got v=%b rw=%b stall=%b exp 0 0 0",
               ex_if.ex_valid, ex_if.ex_reg_write, id_stall);
    end
    tick();
    checks++;
    if (ex_if.ex_valid !== 1'b1 || ex_if.ex_rd !== 5'd5 ||
        ex_if.ex_pc !== 32'h204) begin
      failures++;
      $display("FAIL lu_issue got v=%b rd=%0d pc=%h exp 1 5 204",
               ex_if.ex_valid, ex_if.ex_rd, ex_if.ex_pc);
    end
    drive(1'b1, I_LDW, 32'h208);
    tick();
    drive(1'b1, I_ORI, 32'h20C);
    #1;
    checks++;
    if (id_stall !== 1'b0) begin
      failures++;
      $display("FAIL rt_dest_nostall got %b exp 0", id_stall);
    end
    tick();
    checks++;
    if (ex_if.ex_valid !== 1'b1 || ex_if.ex_rd !== 5'd4) begin
      failures++;
      $display("FAIL ori got v=%b rd=%0d exp 1 4",
               ex_if.ex_valid, ex_if.ex_rd);
    end
  endtask

  task automatic test_bypass();
    regs[1] = 32'd0;
    wb_we   = 1'b1;
    wb_rd   = 5'd1;
    wb_data = 32'h1234;
    drive(1'b1, I_ADDIM1, 32'h300);
    tick();
    wb_we = 1'b0;
    checks++;
    if (ex_if.ex_a !== 32'h1234 || ex_if.ex_imm !== 32'hFFFF_FFFF ||
        ex_if.ex_use_imm !== 1'b1 || ex_if.ex_rd !== 5'd2) begin
      failures++;
      $display("FAIL bypass got a=%h imm=%h ui=%b rd=%0d exp 1234 ffffffff 1 2",
               ex_if.ex_a, ex_if.ex_imm, ex_if.ex_use_imm, ex_if.ex_rd);
    end
    regs[1] = 32'd5;
    drive(1'b1, I_ADDIR0, 32'h304);
    tick();
    checks++;
    if (ex_if.ex_valid !== 1'b1 || ex_if.ex_reg_write !== 1'b0) begin
      failures++;
      $display("FAIL r0_dest got v=%b rw=%b exp 1 0",
               ex_if.ex_valid, ex_if.ex_reg_write);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, I_LDW, 32'h400);
    tick();
    drive(1'b1, I_ADD2, 32'h404);
    flush = 1'b1;
    #1;
    checks++;
    if (id_stall !== 1'b0) begin
      failures++;
      $display("FAIL flush_stall got %b exp 0", id_stall);
    end
    tick();
    flush = 1'b0;
    checks++;
    if (ex_if.ex_valid !== 1'b0 || ex_if.ex_mem_read !== 1'b0) begin
      failures++;
      $display("FAIL flush_bubble got v=%b mr=%b exp 0 0",
               ex_if.ex_valid, ex_if.ex_mem_read);
    end
  endtask

  task automatic test_illegal();
    drive(1'b1, I_ILL, 32'h500);
    tick();
    checks++;
    if (ex_if.ex_valid !== 1'b1 || ex_if.ex_illegal !== 1'b1 ||
        ex_if.ex_reg_write !== 1'b0 || ex_if.ex_mem_read !== 1'b0 ||
        ex_if.ex_mem_write !== 1'b0 || ex_if.ex_halt !== 1'b0) begin
      failures++;
      $display("FAIL illegal got v=%b il=%b rw=%b mr=%b mw=%b h=%b exp 1 1 0 0 0 0",
               ex_if.ex_valid, ex_if.ex_illegal, ex_if.ex_reg_write,
               ex_if.ex_mem_read, ex_if.ex_mem_write, ex_if.ex_halt);
    end
  endtask

  task automatic test_halt();
    drive(1'b1, I_HALT, 32'h600);
    tick();
    checks++;
    if (ex_if.ex_halt !== 1'b1 || ex_if.ex_valid !== 1'b1 ||
        id_stall !== 1'b1) begin
      failures++;
      $display("FAIL halt got h=%b v=%b stall=%b exp 1 1 1",
               ex_if.ex_halt, ex_if.ex_valid, id_stall);
    end
    drive(1'b1, I_ADD, 32'h604);
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (id_stall !== 1'b1 || ex_if.ex_valid !== 1'b0 ||
          ex_if.ex_halt !== 1'b0) begin
        failures++;
        $display("FAIL halted_%0d got stall=%b v=%b h=%b exp 1 0 0",
                 i, id_stall, ex_if.ex_valid, ex_if.ex_halt);
      end
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (id_stall !== 1'b0 || ex_if.ex_valid !== 1'b0 ||
        ex_if.ex_pc !== 32'h0) begin
      failures++;
      $display("FAIL async_reset got stall=%b v=%b pc=%h exp 0 0 0",
               id_stall, ex_if.ex_valid, ex_if.ex_pc);
    end
    tick();
    #2;
    reset_n = 1'b1;
    tick();
    checks++;
    if (ex_if.ex_valid !== 1'b1 || ex_if.ex_rd !== 5'd3 ||
        id_stall !== 1'b0) begin
      failures++;
      $display("FAIL post_reset got v=%b rd=%0d stall=%b exp 1 3 0",
               ex_if.ex_valid, ex_if.ex_rd, id_stall);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    regs[0] = 32'h99;
    regs[1] = 32'd5;
    regs[2] = 32'd7;
    wb_we   = 1'b0;
    wb_rd   = 5'd0;
    wb_data = 32'h0;
    flush   = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    test_reset();
    test_alu();
    test_load_use();
    test_bypass();
    test_flush();
    test_illegal();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
